// File: rtl/i2s_video_rx.sv
// I2S receiver: oversamples bclk/ws/data in the mclk domain and rebuilds WORD_W-bit words,
// with sync-word flagging, short-word and dead-link detection. Define I2S_RX_ERRCNT_EN to enable err_count.
module i2s_video_rx #(
  parameter int                 WORD_W      = 16,
  parameter logic [WORD_W-1:0]  SYNC_WORD   = 16'hFFFF,
  parameter int                 TIMEOUT     = 256,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              i2s_bclk,
  input  logic              i2s_ws,
  input  logic              i2s_data,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_valid,
  output logic              rx_chan,
  output logic              sof,
  output logic              short_err,
  output logic              link_idle,
  output logic [7:0]        err_count
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, ARM, SHIFT, PAD} state_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_bclk_d;

  logic [CNT_W-1:0]  r_idle_cnt;
  logic              r_link_idle;

  state_t            r_state;
  logic [WORD_W-2:0] r_shift;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_chan;
  logic              r_ws_last;
  logic [WORD_W-1:0] r_rx_word;
  logic              r_rx_chan;
  logic              r_rx_valid;
  logic              r_short_err;

  logic              w_bclk_s;
  logic              w_ws_s;
  logic              w_data_s;
  logic              w_bclk_rise;
  logic              w_ws_edge;
  logic              w_timeout;
  logic [WORD_W-1:0] w_shift_next;

  // NOTE: every flop here uses <= so all stages sample the pre-edge value; blocking '=' would collapse the chain.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_bclk_sync <= '0;
      r_ws_sync   <= '0;
      r_data_sync <= '0;
      r_bclk_d    <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], i2s_ws};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i2s_data};
      r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_bclk_s     = r_bclk_sync[SYNC_STAGES-1];
  assign w_ws_s       = r_ws_sync[SYNC_STAGES-1];
  assign w_data_s     = r_data_sync[SYNC_STAGES-1];
  assign w_bclk_rise  = w_bclk_s & ~r_bclk_d;
  assign w_ws_edge    = w_ws_s != r_ws_last;
  assign w_timeout    = r_idle_cnt == IDLE_MAX;
  assign w_shift_next = {r_shift, w_data_s};

  // The idle counter comes out of reset saturated so the link reads idle until bclk is seen.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_idle_cnt  <= IDLE_MAX;
      r_link_idle <= 1'b1;
    end else if (w_bclk_rise) begin
      r_idle_cnt  <= '0;
      r_link_idle <= 1'b0;
    end else if (w_timeout) begin
      r_link_idle <= 1'b1;
    end else begin
      r_idle_cnt  <= r_idle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state     <= HUNT;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_chan      <= 1'b0;
      r_ws_last   <= 1'b0;
      r_rx_word   <= '0;
      r_rx_chan   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_short_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_short_err <= 1'b0;
      if (w_bclk_rise) begin
        r_ws_last <= w_ws_s;
        case (r_state)
          HUNT: if (w_ws_edge) r_state <= ARM;
          ARM: begin
            r_shift   <= {{(WORD_W-2){1'b0}}, w_data_s};
            r_bit_cnt <= BIT_W'(1);
            r_chan    <= w_ws_s;
            r_state   <= SHIFT;
          end
          SHIFT: begin
            r_shift   <= w_shift_next[WORD_W-2:0];
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            // The bit sampled on a WS edge still belongs to this word, so completion wins over the edge.
            if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
              r_rx_word  <= w_shift_next;
              r_rx_chan  <= r_chan;
              r_rx_valid <= 1'b1;
              r_state    <= w_ws_edge ? ARM : PAD;
            end else if (w_ws_edge) begin
              r_short_err <= 1'b1;
              r_state     <= ARM;
            end
          end
          PAD: if (w_ws_edge) r_state <= ARM;
          default: r_state <= HUNT;
        endcase
      end else if (w_timeout) begin
        r_state <= HUNT;
      end
    end
  end

  assign rx_word   = r_rx_word;
  assign rx_valid  = r_rx_valid;
  assign rx_chan   = r_rx_chan;
  assign short_err = r_short_err;
  assign link_idle = r_link_idle;
  assign sof       = r_rx_valid & ~r_rx_chan & (r_rx_word == SYNC_WORD);

`ifdef I2S_RX_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset)                                  r_err_count <= '0;
    else if (r_short_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_video_rx.sv
// Scoreboard bench for i2s_video_rx: builds I2S bit streams, predicts words/short errors by
// segmenting the stream at WS edges, and a monitor compares every rx_valid/short_err pulse.
module tb_i2s_video_rx;

  logic        mclk = 1'b0;
  logic        reset;
  logic        i2s_bclk;
  logic        i2s_ws;
  logic        i2s_data;
  logic [15:0] rx_word;
  logic        rx_valid;
  logic        rx_chan;
  logic        sof;
  logic        short_err;
  logic        link_idle;
  logic [7:0]  err_count;

  i2s_video_rx dut (
    .mclk      (mclk),
    .reset     (reset),
    .i2s_bclk  (i2s_bclk),
    .i2s_ws    (i2s_ws),
    .i2s_data  (i2s_data),
    .rx_word   (rx_word),
    .rx_valid  (rx_valid),
    .rx_chan   (rx_chan),
    .sof       (sof),
    .short_err (short_err),
    .link_idle (link_idle),
    .err_count (err_count)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    bit          is_short;
    logic [15:0] word;
    bit          chan;
  } exp_t;

  exp_t exp_q[$];
  bit   owner_q[$];   // channel owning each bit slot
  bit   data_q[$];
  bit   m_ws_last;
  int   m_err;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge mclk) begin
    if (reset === 1'b0) begin
      if (rx_valid) begin
        check("rx_valid_expected", (exp_q.size() > 0 && !exp_q[0].is_short), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_word", rx_word, e.word);
          check("rx_chan", rx_chan, e.chan);
          check("sof", sof, (e.word == 16'hFFFF && e.chan == 1'b0));
        end
      end
      if (short_err) begin
        check("short_err_expected", (exp_q.size() > 0 && exp_q[0].is_short), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic send_bit(input bit ws, input bit d);
    @(negedge mclk);
    i2s_ws   = ws;
    i2s_data = d;
    repeat (3) @(negedge mclk);
    i2s_bclk = 1'b1;
    repeat (4) @(negedge mclk);
    i2s_bclk = 1'b0;
  endtask

  task automatic add_slot(input bit chan, input logic [15:0] w, input int len);
    for (int i = 0; i < len; i++) begin
      owner_q.push_back(chan);
      data_q.push_back(i < 16 ? w[15-i] : 1'($urandom_range(0, 1)));
    end
  endtask

  // Two lead-in bits owned by the current WS level, plus a filler word if needed,
  // so the first requested slot starts right after a WS edge.
  task automatic start_burst(input bit first_chan);
    owner_q.delete();
    data_q.delete();
    add_slot(m_ws_last, 16'h0000, 2);
    if (first_chan == m_ws_last) add_slot(!m_ws_last, 16'($urandom), 16);
  endtask

  // Reference: a word is the run of bits after one WS edge up to and including the
  // bit that carries the next edge; its first 16 bits form rx_word, fewer is a short word.
  task automatic play(input int n_bits);
    bit          ws_v[$];
    bit          hunting = 1'b1;
    int          seg = 0;
    logic [15:0] acc = '0;
    bit          ch = 1'b0;
    bit          ws;
    bit          edge_b;
    for (int i = 0; i < n_bits; i++) begin
      ws = (i + 1 < owner_q.size()) ? owner_q[i+1] : owner_q[i];
      ws_v.push_back(ws);
      edge_b    = (ws != m_ws_last);
      m_ws_last = ws;
      if (hunting) begin
        if (edge_b) begin
          hunting = 1'b0;
          seg     = 0;
        end
      end else begin
        if (seg == 0) ch = ws;
        seg++;
        if (seg <= 16) acc = {acc[14:0], data_q[i]};
        if (seg == 16) exp_q.push_back('{is_short: 1'b0, word: acc, chan: ch});
        if (edge_b) begin
          if (seg < 16) begin
            exp_q.push_back('{is_short: 1'b1, word: 16'h0000, chan: 1'b0});
            if (m_err < 255) m_err++;
          end
          seg = 0;
        end
      end
    end
    for (int i = 0; i < n_bits; i++) send_bit(ws_v[i], data_q[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_word"}, rx_word, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_chan"}, rx_chan, 0);
    check({tag, "_sof"}, sof, 0);
    check({tag, "_short_err"}, short_err, 0);
    check({tag, "_link_idle"}, link_idle, 1);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  function automatic int exp_err_count();
`ifdef I2S_RX_ERRCNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit c;
    reset    = 1'b1;
    i2s_bclk = 1'b0;
    i2s_ws   = 1'b0;
    i2s_data = 1'b0;
    m_ws_last = 1'b0;
    m_err     = 0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check_reset_vals("por");

    // Sync word on the left, ordinary word on the right.
    start_burst(1'b0);
    add_slot(1'b0, 16'hFFFF, 16);
    add_slot(1'b1, 16'h8F7F, 16);
    play(owner_q.size());
    idle(300);

    // 24-bit slots: the 8 padding bits must be ignored.
    start_burst(1'b0);
    for (int k = 0; k < 4; k++) add_slot(1'(k), 16'h1234, 24);
    play(owner_q.size());
    idle(300);

    // Short word of 10 bits, then a good word.
    start_burst(1'b0);
    add_slot(1'b0, 16'($urandom), 10);
    add_slot(1'b1, 16'hA5A5, 16);
    add_slot(1'b0, 16'($urandom), 16);
    play(owner_q.size());
    idle(300);
    check("err_count_after_short", err_count, exp_err_count());

    // Stall mid-word: idle without a short error, then recover on the next WS edge.
    start_burst(1'b1);
    add_slot(1'b1, 16'($urandom), 16);
    add_slot(1'b0, 16'($urandom), 8);
    play(owner_q.size());
    idle(200);
    check("link_idle_before_timeout", link_idle, 0);
    idle(100);
    check("link_idle_after_timeout", link_idle, 1);
    start_burst(1'b1);
    add_slot(1'b1, 16'h00FF, 16);
    add_slot(1'b0, 16'($urandom), 16);
    play(owner_q.size());
    check("link_idle_after_restart", link_idle, 0);
    idle(300);

    // Sync value on the right channel is not a start of frame.
    start_burst(1'b1);
    add_slot(1'b1, 16'hFFFF, 16);
    add_slot(1'b0, 16'($urandom), 16);
    play(owner_q.size());
    idle(300);

    // Reset during bit 7 of a word.
    start_burst(1'b0);
    add_slot(1'b0, 16'($urandom), 16);
    n = owner_q.size() - 16 + 7;
    play(n);
    @(negedge mclk);
    i2s_ws   = owner_q[n+1];
    i2s_data = data_q[n];
    idle(2);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_ws_last = 1'b0;
    m_err     = 0;
    idle(1);
    check_reset_vals("midword_reset");
    idle(20);
    start_burst(1'b1);
    add_slot(1'b1, 16'($urandom), 16);
    add_slot(1'b0, 16'($urandom), 16);
    play(owner_q.size());
    idle(300);

    // Randomised slot lengths, including short words.
    repeat (6) begin
      c = 1'($urandom_range(0, 1));
      start_burst(c);
      repeat ($urandom_range(3, 8)) begin
        add_slot(c, ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(16, 24)));
        c = !c;
      end
      play(owner_q.size());
      idle(300);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    check("err_count_final", err_count, exp_err_count());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
